// File: rtl/change_dispenser.sv
// Greedy change payout: presents one coin at a time to the hopper over a
// valid/ack handshake, drawing from per-denomination inventory counters.
module change_dispenser #(
    parameter int AMT_W    = 8,
    parameter int CNT_W    = 4,
    parameter int INIT_CNT = 8,
    parameter int VAL1     = 5,
    parameter int VAL2     = 10,
    parameter int VAL3     = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             coin_ack,
    input  logic             refill,
    input  logic [1:0]       refill_sel,
    input  logic [CNT_W-1:0] refill_cnt,
    output logic [1:0]       coin_out,
    output logic             coin_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AMT_W-1:0] remaining,
    output logic [2:0]       low_inv
);
    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_PRESENT, S_FINISH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);

    state_t           state_q, state_d;
    logic [1:0]       coin_out_q, coin_out_d;
    logic             coin_valid_q, coin_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] cnt_q [1:3];
    logic [CNT_W-1:0] cnt_d [1:3];
    logic [1:0]       pick;
    logic [CNT_W:0]   refill_sum;

    function automatic logic [AMT_W-1:0] coin_val(input logic [1:0] code);
        case (code)
            2'b01:   coin_val = AMT_W'(VAL1);
            2'b10:   coin_val = AMT_W'(VAL2);
            2'b11:   coin_val = AMT_W'(VAL3);
            default: coin_val = '0;
        endcase
    endfunction

    // Ascending scan so the highest eligible code wins.
    always_comb begin
        pick = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            if (cnt_q[k] != '0 && coin_val(2'(k)) <= remaining_q) begin
                pick = 2'(k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        coin_out_d   = coin_out_q;
        coin_valid_d = coin_valid_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        remaining_d  = remaining_q;
        cnt_d        = cnt_q;
        refill_sum   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = change_amt;
                    busy_d      = 1'b1;
                    state_d     = S_SELECT;
                end
                for (int k = 1; k <= 3; k++) begin
                    if (refill && refill_sel == 2'(k)) begin
                        refill_sum = {1'b0, cnt_q[k]} + {1'b0, refill_cnt};
                        cnt_d[k]   = refill_sum[CNT_W] ? CNT_MAX : refill_sum[CNT_W-1:0];
                    end
                end
            end
            S_SELECT: begin
                if (remaining_q == '0) begin
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_FINISH;
                end else if (pick != 2'b00) begin
                    coin_out_d   = pick;
                    coin_valid_d = 1'b1;
                    state_d      = S_PRESENT;
                end else begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_PRESENT: begin
                if (coin_valid_q && coin_ack) begin
                    remaining_d = remaining_q - coin_val(coin_out_q);
                    for (int k = 1; k <= 3; k++) begin
                        if (coin_out_q == 2'(k)) begin
                            cnt_d[k] = cnt_q[k] - 1'b1;
                        end
                    end
                    coin_valid_d = 1'b0;
                    coin_out_d   = 2'b00;
                    state_d      = S_SELECT;
                end
            end
            default: begin
                done_d  = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            coin_out_q   <= 2'b00;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            remaining_q  <= '0;
            for (int k = 1; k <= 3; k++) begin
                cnt_q[k] <= CNT_INIT;
            end
        end else begin
            state_q      <= state_d;
            coin_out_q   <= coin_out_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            remaining_q  <= remaining_d;
            cnt_q        <= cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_low_inv
            assign low_inv[gi] = (cnt_q[gi+1] == '0);
        end
    endgenerate

    assign coin_out   = coin_out_q;
    assign coin_valid = coin_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign remaining  = remaining_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: transaction-level greedy model plus a per-cycle
// checker, directed scenarios with literal expectations, then random payouts.
module tb_change_dispenser;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] change_amt = '0;
    logic       coin_ack = 1'b0;
    logic       refill = 1'b0;
    logic [1:0] refill_sel = '0;
    logic [3:0] refill_cnt = '0;
    logic [1:0] coin_out;
    logic       coin_valid, busy, done, err;
    logic [7:0] remaining;
    logic [2:0] low_inv;

    change_dispenser dut (
        .clk(clk), .reset(reset), .start(start), .change_amt(change_amt),
        .coin_ack(coin_ack), .refill(refill), .refill_sel(refill_sel),
        .refill_cnt(refill_cnt), .coin_out(coin_out), .coin_valid(coin_valid),
        .busy(busy), .done(done), .err(err), .remaining(remaining), .low_inv(low_inv)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model state
    int  val [1:3] = '{5, 10, 25};
    int  m_cnt [1:3] = '{8, 8, 8};
    int  tmp [1:3];
    int  exp_q[$];
    int  obs[$];
    bit  exp_err = 0;
    bit  in_pay = 0;
    bit  fin;
    int  m_rem = 0;
    int  g = 0;
    int  rem, pk, k;
    bit  mon_en = 0;
    int  done_cnt = 0;
    int  last_err = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            fin = 0;
            if (in_pay) begin
                g++;
                chk("busy_pay", int'(busy), 1);
                chk("remaining_pay", int'(remaining), m_rem);
                if (g == 1) begin
                    chk("valid_select", int'(coin_valid), 0);
                    chk("coin_out_select", int'(coin_out), 0);
                    chk("done_select", int'(done), 0);
                end else if (exp_q.size() > 0) begin
                    chk("valid_present", int'(coin_valid), 1);
                    chk("coin_out_present", int'(coin_out), exp_q[0]);
                    chk("done_present", int'(done), 0);
                end else begin
                    chk("done_finish", int'(done), 1);
                    chk("err_finish", int'(err), int'(exp_err));
                    chk("valid_finish", int'(coin_valid), 0);
                    fin = 1;
                end
            end else begin
                chk("busy_idle", int'(busy), 0);
                chk("valid_idle", int'(coin_valid), 0);
                chk("coin_out_idle", int'(coin_out), 0);
                chk("done_idle", int'(done), 0);
                chk("err_idle", int'(err), 0);
                chk("remaining_idle", int'(remaining), m_rem);
            end
            for (int i = 1; i <= 3; i++) begin
                chk($sformatf("cnt%0d", i), int'(dut.cnt_q[i]), m_cnt[i]);
            end
            chk("low_inv", int'(low_inv),
                {29'd0, m_cnt[3] == 0, m_cnt[2] == 0, m_cnt[1] == 0});
            if (done) begin
                done_cnt++;
                last_err = int'(err);
            end

            if (reset) begin
                m_cnt = '{8, 8, 8};
                in_pay = 0;
                m_rem = 0;
                exp_q.delete();
            end else if (in_pay) begin
                if (fin) begin
                    in_pay = 0;
                end else if (g >= 2 && exp_q.size() > 0 && coin_ack) begin
                    obs.push_back(int'(coin_out));
                    k = exp_q.pop_front();
                    m_rem -= val[k];
                    m_cnt[k]--;
                    g = 0;
                end
            end else begin
                if (refill && refill_sel != 2'b00) begin
                    k = int'(refill_sel);
                    m_cnt[k] = (m_cnt[k] + int'(refill_cnt) > 15) ? 15 : m_cnt[k] + int'(refill_cnt);
                end
                if (start) begin
                    // Greedy plan: repeatedly take the largest coin that fits and is in stock.
                    rem = int'(change_amt);
                    tmp = m_cnt;
                    exp_q.delete();
                    exp_err = 0;
                    while (rem > 0) begin
                        pk = 0;
                        for (int j = 1; j <= 3; j++) begin
                            if (tmp[j] > 0 && val[j] <= rem) pk = j;
                        end
                        if (pk == 0) begin
                            exp_err = 1;
                            break;
                        end
                        exp_q.push_back(pk);
                        tmp[pk]--;
                        rem -= val[pk];
                    end
                    m_rem = int'(change_amt);
                    in_pay = 1;
                    g = 0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        reset = 1'b1;
        start = 1'b0;
        refill = 1'b0;
        coin_ack = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // ack_mode: 0 tied high, 1 random, 2 first coin held unacknowledged for 5 cycles
    task automatic payout(input int amt, input int ack_mode, input bit rf, input int rsel,
                          input int rcnt, input bit noise);
        bit ok;
        int hold;
        ok = 0;
        hold = 0;
        obs.delete();
        done_cnt = 0;
        start = 1'b1;
        change_amt = 8'(amt);
        refill = rf;
        refill_sel = 2'(rsel);
        refill_cnt = 4'(rcnt);
        coin_ack = (ack_mode == 0);
        tick;
        start = 1'b0;
        refill = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                ok = 1;
                break;
            end
            case (ack_mode)
                0: coin_ack = 1'b1;
                1: coin_ack = 1'($urandom_range(0, 1));
                default: begin
                    if (coin_valid && hold < 5) begin
                        coin_ack = 1'b0;
                        hold++;
                    end else begin
                        coin_ack = 1'b1;
                    end
                end
            endcase
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                change_amt = 8'($urandom);
                refill = 1'($urandom_range(0, 1));
                refill_sel = 2'($urandom);
                refill_cnt = 4'($urandom);
            end
            tick;
        end
        start = 1'b0;
        refill = 1'b0;
        coin_ack = 1'b0;
        chk("payout_completed", int'(ok), 1);
        tick;
    endtask

    task automatic chk_obs(input string name, input int n, input int e0, input int e1, input int e2);
        int e [3];
        e = '{e0, e1, e2};
        chk({name, "_count"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++) begin
            chk($sformatf("%s_coin%0d", name, i), obs[i], e[i]);
        end
    endtask

    initial begin
        reset = 1'b1;
        tick;
        tick;
        mon_en = 1;
        reset = 1'b0;
        tick;
        chk("reset_busy", int'(busy), 0);
        chk("reset_remaining", int'(remaining), 0);
        chk("reset_low_inv", int'(low_inv), 0);

        // 40 = 25 + 10 + 5 with ack tied high
        payout(40, 0, 0, 0, 0, 0);
        chk_obs("pay40", 3, 3, 2, 1);
        chk("pay40_done_cnt", done_cnt, 1);
        chk("pay40_err", last_err, 0);
        chk("pay40_remaining", int'(remaining), 0);
        for (int i = 1; i <= 3; i++) chk($sformatf("pay40_cnt%0d", i), int'(dut.cnt_q[i]), 7);

        // Same payout, first coin held for five cycles
        reset_dut;
        payout(40, 2, 0, 0, 0, 0);
        chk_obs("pay40_hold", 3, 3, 2, 1);
        chk("pay40_hold_done_cnt", done_cnt, 1);

        // 28 pays one quarter then fails with 3 owed
        reset_dut;
        payout(28, 0, 0, 0, 0, 0);
        chk_obs("pay28", 1, 3, 0, 0);
        chk("pay28_err", last_err, 1);
        chk("pay28_remaining", int'(remaining), 3);
        chk("pay28_cnt1", int'(dut.cnt_q[1]), 8);
        chk("pay28_cnt2", int'(dut.cnt_q[2]), 8);
        chk("pay28_cnt3", int'(dut.cnt_q[3]), 7);

        // Drain the quarters, then 25 must come as 10+10+5
        reset_dut;
        for (int i = 0; i < 8; i++) payout(25, 0, 0, 0, 0, 0);
        chk("drain_low_inv", int'(low_inv), 4);
        payout(25, 0, 0, 0, 0, 0);
        chk_obs("pay25_noq", 3, 2, 2, 1);
        chk("pay25_noq_err", last_err, 0);

        // Saturating refill, then a refill attempted while busy
        reset_dut;
        refill = 1'b1;
        refill_sel = 2'b11;
        refill_cnt = 4'd15;
        tick;
        refill = 1'b0;
        tick;
        chk("refill_saturate", int'(dut.cnt_q[3]), 15);
        payout(100, 0, 0, 0, 0, 1);
        chk("refill_busy_cnt3", int'(dut.cnt_q[3]), 11);

        // Reset in the middle of a presented coin
        reset_dut;
        done_cnt = 0;
        start = 1'b1;
        change_amt = 8'd40;
        tick;
        start = 1'b0;
        for (int c = 0; c < 10 && !coin_valid; c++) tick;
        chk("midreset_valid_before", int'(coin_valid), 1);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midreset_valid", int'(coin_valid), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_remaining", int'(remaining), 0);
        for (int i = 1; i <= 3; i++) chk($sformatf("midreset_cnt%0d", i), int'(dut.cnt_q[i]), 8);
        tick;
        tick;
        chk("midreset_no_done", done_cnt, 0);

        // Randomized payouts with refills and busy-time noise
        reset_dut;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                refill = 1'b1;
                refill_sel = 2'($urandom);
                refill_cnt = 4'($urandom);
                tick;
                refill = 1'b0;
            end
            for (int j = $urandom_range(0, 2); j > 0; j--) tick;
            payout($urandom_range(0, 120), $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Return-direction counterpart to the coin-accept path of the vending machine.
- After a sale, the controller hands this block a change amount. The block pays it out one coin at a time to the coin hopper over a valid/ack handshake.
- Coins are chosen greedily, largest first, from per-denomination inventory counters.
- The block reports completion, or an error when it cannot make exact change.

Parameters:
- AMT_W, 8, width of change amount and remaining balance
- CNT_W, 4, width of each inventory counter
- INIT_CNT, 8, value loaded into every inventory counter at reset
- VAL1, 5, value of coin code 2'b01
- VAL2, 10, value of coin code 2'b10
- VAL3, 25, value of coin code 2'b11

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request payout of change_amt; sampled in IDLE only
- change_amt  input  AMT_W  amount to return, captured when start is accepted
- coin_ack  input  1  hopper has taken the presented coin
- refill  input  1  add coins to inventory; honoured in IDLE only
- refill_sel  input  2  coin code to refill (01/10/11); 00 is ignored
- refill_cnt  input  CNT_W  number of coins to add
- coin_out  output  2  code of the presented coin (01/10/11); 00 when none is presented
- coin_valid  output  1  coin_out is valid; held until acknowledged
- busy  output  1  payout in progress (not IDLE)
- done  output  1  one-cycle pulse at end of payout
- err  output  1  valid with done: exact change could not be made
- remaining  output  AMT_W  change still owed
- low_inv  output  3  bit k-1 = 1 when the counter for code k is zero

Behaviour:
- Reset (synchronous, active-high, highest priority in every state):
  - state goes to IDLE
  - coin_out=00, coin_valid=0, busy=0, done=0, err=0, remaining=0
  - all counters load INIT_CNT, so low_inv=000
- All outputs are registered.
- State IDLE:
  - On start=1: remaining<=change_amt, go to SELECT, busy=1 from the next cycle.
  - On refill=1 with refill_sel!=00: add refill_cnt to the selected counter, saturating at 2^CNT_W-1.
  - start and refill in the same cycle: both take effect; SELECT sees the updated count.
- State SELECT (one cycle):
  - If remaining==0: go to FINISH with err=0.
  - Otherwise pick the highest code k with VALk<=remaining and cnt_k>0.
  - Coin found: coin_out<=k, coin_valid<=1, go to PRESENT.
  - No coin found: go to FINISH with err=1; remaining keeps the unpaid amount.
- State PRESENT:
  - coin_out and coin_valid are held stable until coin_ack=1.
  - On a cycle with coin_valid & coin_ack:
    - remaining<=remaining-VALk
    - cnt_k<=cnt_k-1
    - next cycle: coin_valid=0, coin_out=00, state=SELECT
  - coin_ack outside PRESENT is ignored.
- State FINISH (one cycle):
  - done=1 and err as decided in SELECT.
  - Next cycle: back to IDLE with busy=0 and done=0; err clears to 0.
- Latency:
  - start sampled at edge N gives SELECT at N+1 and the first coin_valid at N+2.
  - Minimum 2 cycles per coin when coin_ack is tied high.
  - change_amt=0 gives done two cycles after start, with no coins presented.
- start, refill and change_amt are ignored while busy.
- Greedy selection is the contract: a greedy failure reports err even when another coin combination exists.
- Subtraction never underflows, because only coins with VALk<=remaining are selected.
- low_inv is combinational from the counters.

Test Plan:
- After reset, start with change_amt=40, coin_ack tied high → coins 11, 10, 01 in that order; remaining goes 40→15→5→0; done pulses once with err=0; each counter reads 7.
- Same stimulus with coin_ack held low for 5 cycles on the first coin → coin_out=11 and coin_valid=1 stay stable for all 5 cycles; remaining stays 40; the transfer completes on the ack.
- change_amt=28 → one coin 11 paid; done=1 with err=1; remaining=3; only the code-11 counter decremented.
- Eight payouts of 25, then a ninth payout of 25 → after the eighth, low_inv=100; the ninth pays 10, 10, 5 with err=0.
- In IDLE, refill_sel=11 with refill_cnt=15 while the count is 8 → count saturates at 15. A refill issued while busy → count unchanged.
- reset asserted while coin_valid=1 mid-payout → next cycle coin_valid=0, busy=0, remaining=0, all counters 8, no done pulse.
